// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported unified memory between the
// instruction-fetch requester and the data requester of the pipeline.
// Data wins simultaneous requests; a pending fetch is granted straight from
// DONE, so fetch waits for at most one data access.
// Optional build macro ARB_PERF_EN adds the if_wait_cnt contention counter.
module mem_port_arbiter #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned LAT  = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_req,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [XLEN-1:0] d_wdata,
  output logic            port_sel,
  output logic            port_en,
  output logic            port_we,
  output logic [XLEN-1:0] port_wdata,
  input  logic [XLEN-1:0] port_rdata,
  output logic [XLEN-1:0] if_rdata,
  output logic            if_valid,
  output logic [XLEN-1:0] d_rdata,
  output logic            d_valid,
`ifdef ARB_PERF_EN
  output logic [31:0]     if_wait_cnt,
`endif
  output logic            if_stall,
  output logic            d_stall
);

  localparam int unsigned   CW       = (LAT > 1) ? $clog2(LAT) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(LAT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_DONE
  } state_e;

  state_e          state_q;
  logic            owner_q;
  logic [CW-1:0]   cnt_q;
  logic            port_sel_q;
  logic            port_en_q;
  logic            port_we_q;
  logic [XLEN-1:0] port_wdata_q;
  logic [XLEN-1:0] if_rdata_q;
  logic [XLEN-1:0] d_rdata_q;
  logic            if_valid_q;
  logic            d_valid_q;
  logic            grant_d;
  logic            winner_d;

  // Arbitration: data first from IDLE; from DONE only the non-owner may be granted.
  always_comb begin
    grant_d  = 1'b0;
    winner_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (d_req) begin
          grant_d  = 1'b1;
          winner_d = 1'b1;
        end else if (if_req) begin
          grant_d  = 1'b1;
          winner_d = 1'b0;
        end
      end
      S_DONE: begin
        if (!owner_q && d_req) begin
          grant_d  = 1'b1;
          winner_d = 1'b1;
        end else if (owner_q && if_req) begin
          grant_d  = 1'b1;
          winner_d = 1'b0;
        end
      end
      default: begin
        grant_d  = 1'b0;
        winner_d = 1'b0;
      end
    endcase
  end

  // Access sequencer: port controls are registered at grant and dropped at the last ACCESS cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      owner_q      <= 1'b0;
      cnt_q        <= '0;
      port_sel_q   <= 1'b0;
      port_en_q    <= 1'b0;
      port_we_q    <= 1'b0;
      port_wdata_q <= '0;
      if_rdata_q   <= '0;
      d_rdata_q    <= '0;
      if_valid_q   <= 1'b0;
      d_valid_q    <= 1'b0;
    end else begin
      if_valid_q <= 1'b0;
      d_valid_q  <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE: begin
          if (grant_d) begin
            state_q      <= S_ACCESS;
            owner_q      <= winner_d;
            cnt_q        <= CNT_INIT;
            port_en_q    <= 1'b1;
            port_sel_q   <= winner_d;
            port_we_q    <= winner_d & d_we;
            port_wdata_q <= winner_d ? d_wdata : '0;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_ACCESS: begin
          if (cnt_q == '0) begin
            state_q      <= S_DONE;
            port_en_q    <= 1'b0;
            port_we_q    <= 1'b0;
            port_wdata_q <= '0;
            if (owner_q) begin
              d_rdata_q <= port_rdata;
              d_valid_q <= 1'b1;
            end else begin
              if_rdata_q <= port_rdata;
              if_valid_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

`ifdef ARB_PERF_EN
  logic [31:0] if_wait_cnt_q;

  // Counts fetch cycles lost while the data side owns the port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if_wait_cnt_q <= '0;
    end else if (if_req && owner_q && (state_q == S_ACCESS || state_q == S_DONE)) begin
      if_wait_cnt_q <= if_wait_cnt_q + 32'd1;
    end
  end

  assign if_wait_cnt = if_wait_cnt_q;
`endif

  assign port_sel   = port_sel_q;
  assign port_en    = port_en_q;
  assign port_we    = port_we_q;
  assign port_wdata = port_wdata_q;
  assign if_rdata   = if_rdata_q;
  assign d_rdata    = d_rdata_q;
  assign if_valid   = if_valid_q;
  assign d_valid    = d_valid_q;
  assign if_stall   = if_req & ~if_valid_q;
  assign d_stall    = d_req & ~d_valid_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: requester tasks push expected
// responses; a negedge monitor checks access windows and pops on valid.
module tb_mem_port_arbiter;

  localparam int XLEN = 32;
  localparam int LAT  = 2;

  typedef struct {
    logic [31:0] data;
    int          t0;
    int          lmin;
    int          lmax;
  } exp_t;

  logic            clk;
  logic            rst;
  logic            if_req;
  logic            d_req;
  logic            d_we;
  logic [XLEN-1:0] d_wdata;
  logic            port_sel;
  logic            port_en;
  logic            port_we;
  logic [XLEN-1:0] port_wdata;
  logic [XLEN-1:0] port_rdata;
  logic [XLEN-1:0] if_rdata;
  logic            if_valid;
  logic [XLEN-1:0] d_rdata;
  logic            d_valid;
  logic            if_stall;
  logic            d_stall;
`ifdef ARB_PERF_EN
  logic [31:0]     if_wait_cnt;
`endif

  logic [31:0] if_tok;
  logic [31:0] d_tok;
  int          total;
  int          bad;
  int          cyc;
  int          run;
  logic        wsel;
  logic        ended;
  logic        grants[$];
  exp_t        ifq[$];
  exp_t        dq[$];
  exp_t        me;

  mem_port_arbiter #(.XLEN(XLEN), .LAT(LAT)) dut (
    .clk        (clk),
    .rst        (rst),
    .if_req     (if_req),
    .d_req      (d_req),
    .d_we       (d_we),
    .d_wdata    (d_wdata),
    .port_sel   (port_sel),
    .port_en    (port_en),
    .port_we    (port_we),
    .port_wdata (port_wdata),
    .port_rdata (port_rdata),
    .if_rdata   (if_rdata),
    .if_valid   (if_valid),
    .d_rdata    (d_rdata),
    .d_valid    (d_valid),
`ifdef ARB_PERF_EN
    .if_wait_cnt(if_wait_cnt),
`endif
    .if_stall   (if_stall),
    .d_stall    (d_stall)
  );

  // Memory model: each requester's token is the content at its address.
  assign port_rdata = port_en ? (port_sel ? d_tok : if_tok) : 32'h0BAD0BAD;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic check_lat(input string nm, input int lat, input int lmin, input int lmax);
    total++;
    if (lat < lmin || lat > lmax) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d..%0d (cycle %0d)", nm, lat, lmin, lmax, cyc);
    end
  endtask

  task automatic check_zero(input string nm);
    check({nm, "_port_sel"}, port_sel, 1'b0);
    check({nm, "_port_en"}, port_en, 1'b0);
    check({nm, "_port_we"}, port_we, 1'b0);
    check({nm, "_port_wdata"}, port_wdata, 32'h0);
    check({nm, "_if_rdata"}, if_rdata, 32'h0);
    check({nm, "_d_rdata"}, d_rdata, 32'h0);
    check({nm, "_if_valid"}, if_valid, 1'b0);
    check({nm, "_d_valid"}, d_valid, 1'b0);
`ifdef ARB_PERF_EN
    check({nm, "_if_wait_cnt"}, if_wait_cnt, 32'h0);
`endif
  endtask

  // Called at posedge+#1; returns at posedge+#1 after the valid pulse.
  task automatic issue_if(input logic [31:0] tok, input int lmin, input int lmax);
    exp_t e;
    if_tok = tok;
    if_req = 1'b1;
    e = '{tok, cyc, lmin, lmax};
    ifq.push_back(e);
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (if_valid) break;
    end
    check("if_done", if_valid, 1'b1);
    @(posedge clk);
    #1;
    if_req = 1'b0;
  endtask

  task automatic issue_d(input logic [31:0] tok, input logic we, input logic [31:0] wd,
                         input int lmin, input int lmax);
    exp_t e;
    d_tok   = tok;
    d_we    = we;
    d_wdata = wd;
    d_req   = 1'b1;
    e = '{tok, cyc, lmin, lmax};
    dq.push_back(e);
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (d_valid) break;
    end
    check("d_done", d_valid, 1'b1);
    @(posedge clk);
    #1;
    d_req = 1'b0;
  endtask

  task automatic rand_if(input int n);
    for (int i = 0; i < n; i++) begin
      int gap;
      gap = $urandom_range(0, 3);
      repeat (gap) begin
        @(posedge clk);
        #1;
      end
      issue_if($urandom, LAT + 1, 2 * LAT + 2);
    end
  endtask

  task automatic rand_d(input int n);
    for (int i = 0; i < n; i++) begin
      int gap;
      gap = $urandom_range(0, 3);
      repeat (gap) begin
        @(posedge clk);
        #1;
      end
      issue_d($urandom, 1'($urandom_range(0, 1)), $urandom, LAT + 1, 2 * LAT + 2);
    end
  endtask

  task automatic pulse_reset(input string nm);
    rst = 1'b1;
    #1;
    check_zero(nm);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Monitor: access windows, valid ownership, stalls and scoreboard pops.
  always @(negedge clk) begin
    if (rst) begin
      run = 0;
    end else begin
      ended = (!port_en && run > 0);
      if (port_en) begin
        if (run == 0) begin
          wsel = port_sel;
          grants.push_back(port_sel);
        end else begin
          check("sel_stable", port_sel, wsel);
        end
        check("port_we", port_we, wsel & d_we);
        check("port_wdata", port_wdata, wsel ? d_wdata : 32'h0);
        run++;
      end
      if (ended) begin
        check("access_len", run, LAT);
        run = 0;
      end
      if (ended || if_valid || d_valid)
        check("valid_owner", {if_valid, d_valid}, ended ? (wsel ? 2'b01 : 2'b10) : 2'b00);
      check("if_stall", if_stall, if_req & ~if_valid);
      check("d_stall", d_stall, d_req & ~d_valid);
      if (if_valid) begin
        if (ifq.size() > 0) begin
          me = ifq.pop_front();
          check("if_rdata", if_rdata, me.data);
          check_lat("if_latency", cyc - me.t0, me.lmin, me.lmax);
        end else begin
          check("if_unexpected_valid", if_valid, 1'b0);
        end
      end
      if (d_valid) begin
        if (dq.size() > 0) begin
          me = dq.pop_front();
          check("d_rdata", d_rdata, me.data);
          check_lat("d_latency", cyc - me.t0, me.lmin, me.lmax);
        end else begin
          check("d_unexpected_valid", d_valid, 1'b0);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout cycle=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    clk = 1'b0; rst = 1'b1; cyc = 0; run = 0; wsel = 1'b0;
    total = 0; bad = 0;
    if_req = 1'b0; d_req = 1'b0; d_we = 1'b0; d_wdata = '0;
    if_tok = '0; d_tok = '0;
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Lone fetch: two ACCESS cycles on the fetch address, valid at t+3.
    fork
      issue_if(32'h00500093, LAT + 1, LAT + 1);
      begin
        @(negedge clk);
        check("fetch_t0_en", port_en, 1'b0);
        repeat (LAT) begin
          @(negedge clk);
          check("fetch_en", port_en, 1'b1);
          check("fetch_sel", port_sel, 1'b0);
        end
        @(negedge clk);
        check("fetch_done_en", port_en, 1'b0);
      end
    join
    check("fetch_rdata_held", if_rdata, 32'h00500093);

    // Lone store.
    issue_d(32'h13572468, 1'b1, 32'hDEADBEEF, LAT + 1, LAT + 1);

    // Simultaneous requests: data first, fetch granted from DONE.
    pulse_reset("reset2");
    fork
      issue_d(32'h0000A5A5, 1'b0, 32'h0, LAT + 1, LAT + 1);
      issue_if(32'h00100073, 2 * LAT + 2, 2 * LAT + 2);
      begin
        for (int k = 0; k < 2 * LAT + 2; k++) begin
          @(negedge clk);
          check("cont_if_stall_hi", if_stall, 1'b1);
`ifdef ARB_PERF_EN
          if (k == LAT + 2) check("if_wait_cnt", if_wait_cnt, 32'd3);
`endif
        end
        @(negedge clk);
        check("cont_if_stall_lo", if_stall, 1'b0);
      end
    join

    // Continuous contention: grant order D, I, D, I.
    @(posedge clk);
    #1;
    grants.delete();
    fork
      begin
        issue_d(32'h11111111, 1'b1, 32'hA0A0A0A0, LAT + 1, 2 * LAT + 2);
        issue_d(32'h22222222, 1'b0, 32'h0, LAT + 1, 2 * LAT + 2);
      end
      begin
        issue_if(32'h33333333, LAT + 1, 2 * LAT + 2);
        issue_if(32'h44444444, LAT + 1, 2 * LAT + 2);
      end
    join
    check("grant_count", grants.size(), 4);
    if (grants.size() == 4)
      check("grant_order", {grants[0], grants[1], grants[2], grants[3]}, 4'b1010);

    // Reset in the middle of a store access: everything clears, no pulse follows.
    @(posedge clk);
    #1;
    d_tok = 32'h99999999; d_we = 1'b1; d_wdata = 32'hCAFEF00D; d_req = 1'b1;
    @(posedge clk);
    #3;
    check("mid_en_before_rst", port_en, 1'b1);
    check("mid_we_before_rst", port_we, 1'b1);
    rst = 1'b1;
    #1;
    check_zero("rst_mid");
    d_req = 1'b0; d_we = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (5) @(negedge clk);
    @(posedge clk);
    #1;
    issue_if(32'h00A00113, LAT + 1, LAT + 1);

    // Randomized traffic from both requesters.
    fork
      rand_if(25);
      rand_d(25);
    join
    repeat (4) @(posedge clk);
    check("if_queue_empty", ifq.size(), 0);
    check("d_queue_empty", dq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
